// File: rtl/reg_wb_arbiter.sv
// Writeback arbiter: merges ALU and load writebacks onto one register-file write
// port with round-robin fairness, optionally clearing registers 1..NREG-1 after reset.
module reg_wb_arbiter #(
    parameter int unsigned INIT_EN = 1,
    parameter int unsigned NREG    = 32
) (
    input  logic        SYS_clk,
    input  logic        SYS_reset,
    input  logic        ALU_wb_valid,
    input  logic [5:0]  ALU_wb_addr,
    input  logic [31:0] ALU_wb_data,
    output logic        ALU_wb_ready,
    input  logic        MEM_wb_valid,
    input  logic [5:0]  MEM_wb_addr,
    input  logic [31:0] MEM_wb_data,
    output logic        MEM_wb_ready,
    output logic        REG_write_1,
    output logic [5:0]  REG_address_wr,
    output logic [31:0] REG_data_wb_in1,
    output logic        WB_busy,
    output logic        WB_drop
);

    localparam int unsigned AW = 6;
    localparam int unsigned DW = 32;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;
    localparam logic [0:0] ST_RESET = (INIT_EN != 0) ? ST_INIT : ST_RUN;

    localparam logic LG_ALU = 1'b0;
    localparam logic LG_MEM = 1'b1;

    localparam logic [AW-1:0] CNT_LAST = AW'(NREG - 1);
    localparam logic [AW:0]   NREG_W   = (AW+1)'(NREG);

    logic [0:0]    state_q, state_d;
    logic          lg_q, lg_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          wr_q, wr_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] data_q, data_d;
    logic          drop_q, drop_d;
    logic          busy_q, busy_d;

    logic          alu_gnt_c, mem_gnt_c;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_data;
    logic          sel_ok;

    // Grant: a lone requester wins; on contention the one not granted last wins.
    always_comb begin
        alu_gnt_c = 1'b0;
        mem_gnt_c = 1'b0;
        if (!SYS_reset && state_q == ST_RUN) begin
            if (ALU_wb_valid && MEM_wb_valid) begin
                alu_gnt_c = (lg_q == LG_MEM);
                mem_gnt_c = (lg_q == LG_ALU);
            end else begin
                alu_gnt_c = ALU_wb_valid;
                mem_gnt_c = MEM_wb_valid;
            end
        end
    end

    assign ALU_wb_ready = alu_gnt_c;
    assign MEM_wb_ready = mem_gnt_c;

    always_comb begin
        state_d  = state_q;
        lg_d     = lg_q;
        cnt_d    = cnt_q;
        wr_d     = 1'b0;
        addr_d   = addr_q;
        data_d   = data_q;
        drop_d   = 1'b0;
        busy_d   = busy_q;
        sel_addr = mem_gnt_c ? MEM_wb_addr : ALU_wb_addr;
        sel_data = mem_gnt_c ? MEM_wb_data : ALU_wb_data;
        sel_ok   = (sel_addr != '0) && ({1'b0, sel_addr} < NREG_W);

        case (state_q)
            ST_INIT: begin
                wr_d   = 1'b1;
                addr_d = cnt_q;
                data_d = '0;
                cnt_d  = cnt_q + AW'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_RUN;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                busy_d = 1'b0;
                // Out-of-range destinations are accepted but never written.
                if (alu_gnt_c || mem_gnt_c) begin
                    lg_d = mem_gnt_c ? LG_MEM : LG_ALU;
                    if (sel_ok) begin
                        wr_d   = 1'b1;
                        addr_d = sel_addr;
                        data_d = sel_data;
                    end else begin
                        drop_d = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge SYS_clk) begin
        if (SYS_reset) begin
            state_q <= ST_RESET;
            lg_q    <= LG_ALU;
            cnt_q   <= AW'(1);
            wr_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            drop_q  <= 1'b0;
            busy_q  <= (INIT_EN != 0);
        end else begin
            state_q <= state_d;
            lg_q    <= lg_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            drop_q  <= drop_d;
            busy_q  <= busy_d;
        end
    end

    assign REG_write_1     = wr_q;
    assign REG_address_wr  = addr_q;
    assign REG_data_wb_in1 = data_q;
    assign WB_drop         = drop_q;
    assign WB_busy         = busy_q;

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Bench for reg_wb_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model of the arbitration and writeback rules.
module tb_reg_wb_arbiter;

    localparam int NREG = 32;

    logic        SYS_clk = 1'b0;
    logic        SYS_reset;
    logic        ALU_wb_valid;
    logic [5:0]  ALU_wb_addr;
    logic [31:0] ALU_wb_data;
    logic        ALU_wb_ready;
    logic        MEM_wb_valid;
    logic [5:0]  MEM_wb_addr;
    logic [31:0] MEM_wb_data;
    logic        MEM_wb_ready;
    logic        REG_write_1;
    logic [5:0]  REG_address_wr;
    logic [31:0] REG_data_wb_in1;
    logic        WB_busy;
    logic        WB_drop;

    logic        n_alu_rdy, n_mem_rdy, n_wr, n_busy, n_drop;
    logic [5:0]  n_addr;
    logic [31:0] n_data;

    int n_pass  = 0;
    int n_total = 0;

    // Model state: who was granted last, and the last committed address/data
    bit          m_lg_mem;
    logic [5:0]  m_addr;
    logic [31:0] m_data;
    bit          last_alu_g, last_mem_g;

    always #5 SYS_clk = ~SYS_clk;

    reg_wb_arbiter #(.INIT_EN(1), .NREG(NREG)) u_dut (
        .SYS_clk(SYS_clk), .SYS_reset(SYS_reset),
        .ALU_wb_valid(ALU_wb_valid), .ALU_wb_addr(ALU_wb_addr),
        .ALU_wb_data(ALU_wb_data), .ALU_wb_ready(ALU_wb_ready),
        .MEM_wb_valid(MEM_wb_valid), .MEM_wb_addr(MEM_wb_addr),
        .MEM_wb_data(MEM_wb_data), .MEM_wb_ready(MEM_wb_ready),
        .REG_write_1(REG_write_1), .REG_address_wr(REG_address_wr),
        .REG_data_wb_in1(REG_data_wb_in1), .WB_busy(WB_busy), .WB_drop(WB_drop)
    );

    reg_wb_arbiter #(.INIT_EN(0), .NREG(NREG)) u_dut_noinit (
        .SYS_clk(SYS_clk), .SYS_reset(SYS_reset),
        .ALU_wb_valid(ALU_wb_valid), .ALU_wb_addr(ALU_wb_addr),
        .ALU_wb_data(ALU_wb_data), .ALU_wb_ready(n_alu_rdy),
        .MEM_wb_valid(MEM_wb_valid), .MEM_wb_addr(MEM_wb_addr),
        .MEM_wb_data(MEM_wb_data), .MEM_wb_ready(n_mem_rdy),
        .REG_write_1(n_wr), .REG_address_wr(n_addr),
        .REG_data_wb_in1(n_data), .WB_busy(n_busy), .WB_drop(n_drop)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge SYS_clk);
        #1;
    endtask

    function automatic logic [5:0] rand_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return 6'd0;
        if (r == 1) return 6'($urandom_range(NREG, 63));
        return 6'($urandom_range(1, NREG - 1));
    endfunction

    task automatic check_reset(input string tag);
        check({tag, ":wr"},      32'(REG_write_1), 32'd0);
        check({tag, ":addr"},    32'(REG_address_wr), 32'd0);
        check({tag, ":data"},    REG_data_wb_in1, 32'd0);
        check({tag, ":drop"},    32'(WB_drop), 32'd0);
        check({tag, ":busy"},    32'(WB_busy), 32'd1);
        check({tag, ":alu_rdy"}, 32'(ALU_wb_ready), 32'd0);
        check({tag, ":mem_rdy"}, 32'(MEM_wb_ready), 32'd0);
    endtask

    // Clearing sequence after reset release: writes 1..n with zero data.
    task automatic init_seq(input int n);
        for (int i = 1; i <= n; i++) begin
            if (i == 5) begin
                ALU_wb_valid = 1'b1;
                MEM_wb_valid = 1'b1;
                #1;
                check("init:alu_rdy", 32'(ALU_wb_ready), 32'd0);
                check("init:mem_rdy", 32'(MEM_wb_ready), 32'd0);
                check("noinit:mem_first", 32'(n_mem_rdy), 32'd1);
                ALU_wb_valid = 1'b0;
                MEM_wb_valid = 1'b0;
            end
            tick();
            check("init:wr",   32'(REG_write_1), 32'd1);
            check("init:addr", 32'(REG_address_wr), 32'(i));
            check("init:data", REG_data_wb_in1, 32'd0);
            check("init:busy", 32'(WB_busy), 32'(i < NREG - 1));
        end
    endtask

    // One RUN cycle: predict grant from the fairness rule, then the write it causes.
    task automatic cycle(input string tag);
        bit          g_alu, g_mem, ok;
        logic [5:0]  a;
        logic [31:0] d;
        bit          e_wr, e_drop;
        #1;
        if (ALU_wb_valid && MEM_wb_valid) begin
            g_alu = m_lg_mem;
            g_mem = !m_lg_mem;
        end else begin
            g_alu = ALU_wb_valid;
            g_mem = MEM_wb_valid;
        end
        check({tag, ":alu_rdy"}, 32'(ALU_wb_ready), 32'(g_alu));
        check({tag, ":mem_rdy"}, 32'(MEM_wb_ready), 32'(g_mem));
        a = g_mem ? MEM_wb_addr : ALU_wb_addr;
        d = g_mem ? MEM_wb_data : ALU_wb_data;
        tick();
        e_wr = 1'b0;
        e_drop = 1'b0;
        if (g_alu || g_mem) begin
            m_lg_mem = g_mem;
            ok = (a != 6'd0) && (int'(a) < NREG);
            e_wr = ok;
            e_drop = !ok;
            if (ok) begin
                m_addr = a;
                m_data = d;
            end
        end
        check({tag, ":wr"},   32'(REG_write_1), 32'(e_wr));
        check({tag, ":drop"}, 32'(WB_drop), 32'(e_drop));
        check({tag, ":addr"}, 32'(REG_address_wr), 32'(m_addr));
        check({tag, ":data"}, REG_data_wb_in1, m_data);
        check({tag, ":busy"}, 32'(WB_busy), 32'd0);
        last_alu_g = g_alu;
        last_mem_g = g_mem;
    endtask

    task automatic random_run(input int n);
        for (int k = 0; k < n; k++) begin
            cycle("rnd");
            // A pending request holds until granted; new ones appear only after a grant or idle.
            if (last_alu_g || !ALU_wb_valid) begin
                ALU_wb_valid = ($urandom_range(0, 3) != 0);
                ALU_wb_addr  = rand_addr();
                ALU_wb_data  = $urandom;
            end
            if (last_mem_g || !MEM_wb_valid) begin
                MEM_wb_valid = ($urandom_range(0, 3) != 0);
                MEM_wb_addr  = rand_addr();
                MEM_wb_data  = $urandom;
            end
        end
        ALU_wb_valid = 1'b0;
        MEM_wb_valid = 1'b0;
    endtask

    initial begin
        SYS_reset    = 1'b1;
        ALU_wb_valid = 1'b0;
        ALU_wb_addr  = '0;
        ALU_wb_data  = '0;
        MEM_wb_valid = 1'b0;
        MEM_wb_addr  = '0;
        MEM_wb_data  = '0;
        m_lg_mem     = 1'b0;
        m_addr       = '0;
        m_data       = '0;
        last_alu_g   = 1'b0;
        last_mem_g   = 1'b0;

        // Reset state, with requests present to confirm ready stays low
        tick();
        tick();
        ALU_wb_valid = 1'b1;
        MEM_wb_valid = 1'b1;
        #1;
        check_reset("reset");
        check("noinit:busy_rst", 32'(n_busy), 32'd0);
        check("noinit:rdy_rst",  32'(n_mem_rdy), 32'd0);
        ALU_wb_valid = 1'b0;
        MEM_wb_valid = 1'b0;

        SYS_reset = 1'b0;
        init_seq(NREG - 1);
        check("noinit:wr", 32'(n_wr), 32'd0);
        m_addr = 6'(NREG - 1);

        // Single ALU writeback
        ALU_wb_valid = 1'b1;
        ALU_wb_addr  = 6'd5;
        ALU_wb_data  = 32'hDEADBEEF;
        cycle("alu_only");
        ALU_wb_valid = 1'b0;
        check("alu_only:addr5", 32'(REG_address_wr), 32'd5);
        check("alu_only:dbeef", REG_data_wb_in1, 32'hDEADBEEF);

        // Sustained contention alternates MEM, ALU, MEM, ALU
        ALU_wb_valid = 1'b1; ALU_wb_addr = 6'd10; ALU_wb_data = 32'hA000_0010;
        MEM_wb_valid = 1'b1; MEM_wb_addr = 6'd11; MEM_wb_data = 32'hB000_0011;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("both:mem_turn", 32'(MEM_wb_ready), 32'(k % 2 == 0));
            cycle("both");
            if (last_alu_g) begin
                ALU_wb_addr = 6'(12 + k);
                ALU_wb_data = 32'hA000_0000 + 32'(k);
            end
            if (last_mem_g) begin
                MEM_wb_addr = 6'(20 + k);
                MEM_wb_data = 32'hB000_0000 + 32'(k);
            end
        end
        ALU_wb_valid = 1'b0;
        MEM_wb_valid = 1'b0;

        // Discarded load to r0
        MEM_wb_valid = 1'b1;
        MEM_wb_addr  = 6'd0;
        MEM_wb_data  = 32'h1234_5678;
        cycle("drop0");
        MEM_wb_valid = 1'b0;
        cycle("drop0_after");

        // Out-of-range ALU destination
        ALU_wb_valid = 1'b1;
        ALU_wb_addr  = 6'd40;
        cycle("drop_hi");
        ALU_wb_valid = 1'b0;

        random_run(300);

        // Reset coinciding with a request: nothing written
        ALU_wb_valid = 1'b1;
        ALU_wb_addr  = 6'd7;
        ALU_wb_data  = 32'h0BAD_F00D;
        SYS_reset    = 1'b1;
        tick();
        check_reset("rst_req");
        ALU_wb_valid = 1'b0;

        // Reset in the middle of INIT restarts the clear at address 1
        SYS_reset = 1'b0;
        init_seq(9);
        SYS_reset = 1'b1;
        tick();
        check_reset("rst_init");
        SYS_reset = 1'b0;
        init_seq(NREG - 1);
        m_lg_mem = 1'b0;
        m_addr   = 6'(NREG - 1);
        m_data   = '0;

        ALU_wb_valid = 1'b1; ALU_wb_addr = 6'd3; ALU_wb_data = 32'h3333_3333;
        MEM_wb_valid = 1'b1; MEM_wb_addr = 6'd3; MEM_wb_data = 32'h4444_4444;
        #1;
        check("post_rst:mem_first", 32'(MEM_wb_ready), 32'd1);
        cycle("same_addr0");
        MEM_wb_valid = 1'b0;
        cycle("same_addr1");
        check("same_addr:last", REG_data_wb_in1, 32'h3333_3333);
        ALU_wb_valid = 1'b0;

        random_run(200);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/reg_wb_arbiter.md
REG_WB_ARBITER -- requirements
Module: reg_wb_arbiter

Interface
REQ-001 The block SHALL have parameter INIT_EN, default 1, meaning that when it is 1 the block clears registers 1..31 after reset, and when it is 0 it goes straight to RUN.
REQ-002 The block SHALL have parameter NREG, default 32, giving the number of register-file entries; valid write addresses are 1..NREG-1.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset: SYS_clk is the single clock and SYS_reset is synchronous and active-high.
REQ-004 The block SHALL have the following ports (name, direction, width, meaning):
- SYS_clk, in, 1, clock; all state changes on the rising edge.
- SYS_reset, in, 1, synchronous active-high reset.
- ALU_wb_valid, in, 1, ALU writeback request.
- ALU_wb_addr, in, 6, ALU destination register.
- ALU_wb_data, in, 32, ALU result.
- ALU_wb_ready, out, 1, ALU request accepted this cycle.
- MEM_wb_valid, in, 1, load writeback request.
- MEM_wb_addr, in, 6, load destination register.
- MEM_wb_data, in, 32, load data.
- MEM_wb_ready, out, 1, MEM request accepted this cycle.
- REG_write_1, out, 1, register-file write enable.
- REG_address_wr, out, 6, register-file write address.
- REG_data_wb_in1, out, 32, register-file write data.
- WB_busy, out, 1, high while in INIT.
- WB_drop, out, 1, one-cycle pulse when an accepted request is discarded.

Function
REQ-005 The block SHALL have exactly two states: INIT and RUN.
REQ-006 In INIT, on each clock the block SHALL register REG_write_1=1, REG_address_wr=cnt and REG_data_wb_in1=0, then increment cnt, with cnt starting at 1.
REQ-007 When the INIT write with cnt=NREG-1 is registered, the block SHALL move to RUN on that same edge; the INIT sequence is exactly NREG-1 writes to consecutive addresses.
REQ-008 In INIT, ALU_wb_ready and MEM_wb_ready SHALL be 0, and WB_busy SHALL be 1.
REQ-009 In RUN, both ready outputs SHALL be combinational functions of the valid inputs and the last-grant pointer lg, with at most one ready high per cycle.
REQ-010 In RUN, when only one requester is valid, that requester SHALL be granted.
REQ-011 In RUN, when both requesters are valid, the requester not named by lg SHALL be granted, and lg SHALL update to the granted requester.
REQ-012 In RUN, when neither requester is valid, there SHALL be no grant and lg SHALL hold its value.
REQ-013 A handshake SHALL complete in any cycle where valid and ready are both 1; a valid request that is not granted SHALL hold its addr and data until it is granted.
REQ-014 The write latency SHALL be one cycle: a grant on edge N causes REG_write_1=1 with the granted addr and data in the cycle after edge N.
REQ-015 An accepted request with addr==0 or addr>=NREG SHALL be discarded: REG_write_1=0 in the following cycle, and WB_drop=1 for exactly that cycle.
REQ-016 In RUN, with no grant, REG_write_1 SHALL be 0 in the following cycle, and REG_address_wr and REG_data_wb_in1 SHALL hold their previous values.
REQ-017 The block SHALL sustain back-to-back grants with no bubble: one write per cycle, with the two requesters alternating while both stay valid.
REQ-018 No request SHALL wait more than 1 cycle while the other requester is granted continuously, which guarantees freedom from starvation.
REQ-019 The block SHALL NOT combine two requests into one write; when two pending requests target the same address, they are committed in grant order.
REQ-020 All outputs except the two ready signals SHALL be registered.

Reset
REQ-021 While SYS_reset=1 at a rising edge, the block SHALL set:
- REG_write_1=0, REG_address_wr=0, REG_data_wb_in1=0, WB_drop=0;
- lg=ALU, so MEM wins the first contention;
- cnt=1;
- state=INIT if INIT_EN=1, otherwise RUN.
REQ-022 While SYS_reset=1, both ready outputs SHALL be 0, and WB_busy SHALL be 1 if INIT_EN=1.
REQ-023 Reset asserted mid-INIT or mid-RUN SHALL abandon all activity; a request in flight is not written, and INIT restarts from address 1.

Verification
REQ-024 Scenario: release reset with INIT_EN=1 -> REG_write_1=1 for 31 consecutive cycles, with addresses 1..31 and data 0; then WB_busy=0 and both ready outputs are available.
REQ-025 Scenario: in RUN, ALU_wb_valid only, addr=5, data=0xDEADBEEF -> ALU_wb_ready=1, and the next cycle shows REG_write_1=1, REG_address_wr=5, REG_data_wb_in1=0xDEADBEEF.
REQ-026 Scenario: both requesters valid for 4 cycles with distinct addresses -> grants go MEM, ALU, MEM, ALU, with 4 writes on consecutive cycles in that order.
REQ-027 Scenario: MEM_wb_valid with addr=0 -> MEM_wb_ready=1, the next cycle shows REG_write_1=0 and WB_drop=1, and the cycle after that shows WB_drop=0.
REQ-028 Scenario: assert SYS_reset at INIT cnt=10 for 1 cycle -> INIT restarts with address 1, for 31 writes in total after release.
REQ-029 Scenario: assert SYS_reset in the same cycle as an accepted ALU request -> no write occurs, and all outputs equal their REQ-021 values.
